// File: rtl/bin2bcd_seq_pkg.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq_pkg
// Shared display-path definitions for the sequential binary-to-BCD converter:
//   - default WIDTH/DIGITS for the eight-digit seven-segment display
//   - BCD digit constants used by the add-3 correction and saturation
//   - converter FSM state encoding
// -----------------------------------------------------------------------------
package bin2bcd_seq_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_DIGITS = 8;

    localparam logic [3:0] BCD_NINE       = 4'h9;
    localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_adj3.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj3
// Double-dabble correction for one BCD digit: digits >= 5 get +3 so that the
// following left shift carries correctly into the next decimal digit.
// Ports:
//   i_digit  in  4  BCD digit before correction
//   o_digit  out 4  corrected digit (no carry out; 5..9 map to 8..12)
// -----------------------------------------------------------------------------
module bcd_digit_adj3
    import bin2bcd_seq_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= ADD3_THRESHOLD) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Feeds the seven-segment scan driver with registered digits and a
// leading-zero blank mask; outputs hold between done pulses.
// Ports:
//   clk       in  1          board clock
//   rst       in  1          asynchronous, active-high reset
//   start     in  1          conversion request, sampled only when idle
//   bin       in  WIDTH      unsigned value, captured on the accepted start
//   busy      out 1          conversion in progress
//   done      out 1          one-cycle pulse when bcd/blank/overflow update
//   bcd       out 4*DIGITS   packed BCD, digit 0 in bits [3:0]
//   blank     out DIGITS     1 = suppress digit (leading zero); bit 0 never set
//   overflow  out 1          last value exceeded 10^DIGITS-1 (bcd saturated)
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DIGITS = DEFAULT_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank,
    output logic                  overflow
);

    localparam int SW    = 4 * DIGITS;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0]  LAST_CNT    = CNT_W'(WIDTH - 1);
    localparam logic [SW-1:0]     BCD_SAT     = {DIGITS{BCD_NINE}};
    localparam logic [DIGITS-1:0] BLANK_RESET = {{(DIGITS-1){1'b1}}, 1'b0};

    state_t             r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [SW-1:0]      r_scratch;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic               r_busy;
    logic               r_done;
    logic [SW-1:0]      r_bcd;
    logic [DIGITS-1:0]  r_blank;
    logic               r_overflow;

    logic [SW-1:0]      w_adj;
    logic [DIGITS-1:0]  w_blank;

    // Add-3 correction on every scratch digit in parallel, no inter-digit carry.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj3 u_adj (
            .i_digit (r_scratch[4*g +: 4]),
            .o_digit (w_adj[4*g +: 4])
        );
    end

    // Digit i is blanked when it and every digit above it are zero; each bit
    // is an independent reduction so there is no ripple chain.
    assign w_blank[0] = 1'b0;
    for (genvar g = 1; g < DIGITS; g++) begin : g_blank
        assign w_blank[g] = ~|r_scratch[SW-1:4*g];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bcd      <= '0;
            r_blank    <= BLANK_RESET;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_shift   <= bin;
                        r_scratch <= '0;
                        r_ovf     <= 1'b0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    // {scratch, shift} shifts left as one register; the bit
                    // leaving the scratch MSB means the value no longer fits.
                    r_scratch <= {w_adj[SW-2:0], r_shift[WIDTH-1]};
                    r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
                    r_ovf     <= r_ovf | w_adj[SW-1];
                    r_cnt     <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    r_bcd      <= r_ovf ? BCD_SAT : r_scratch;
                    r_blank    <= r_ovf ? '0 : w_blank;
                    r_overflow <= r_ovf;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bcd      = r_bcd;
    assign blank    = r_blank;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_seq
// Self-checking bench for bin2bcd_seq. A cycle-level behavioural model built
// from decimal arithmetic predicts every output; a negedge compare process
// checks the DUT against it each cycle, and directed cases pin literals.
// -----------------------------------------------------------------------------
module tb_bin2bcd_seq;

    localparam int WIDTH  = 32;
    localparam int DIGITS = 8;
    localparam int LAT    = WIDTH + 1;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic [WIDTH-1:0]    bin = '0;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
    logic [DIGITS-1:0]   blank;
    logic                overflow;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .blank    (blank),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] model_bcd(input logic [31:0] v);
        int unsigned x;
        logic [31:0] r;
        x = v;
        r = '0;
        if (x > 32'd99999999) return 32'h99999999;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] model_blank(input logic [31:0] v);
        logic [7:0] b;
        logic [31:0] d;
        bit seen;
        b = '0;
        if (v > 32'd99999999) return b;
        d = model_bcd(v);
        seen = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (d[4*i +: 4] != 4'd0) seen = 1'b1;
            b[i] = !seen;
        end
        return b;
    endfunction

    int unsigned      m_rem;
    logic [WIDTH-1:0] m_cap;
    logic             m_busy, m_done, m_ovf;
    logic [31:0]      m_bcd;
    logic [7:0]       m_blank;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rem   <= 0;
            m_cap   <= '0;
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_ovf   <= 1'b0;
            m_bcd   <= '0;
            m_blank <= 8'b1111_1110;
        end else if (m_rem == 0) begin
            m_done <= 1'b0;
            if (start) begin
                m_cap  <= bin;
                m_rem  <= LAT;
                m_busy <= 1'b1;
            end
        end else begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                m_busy  <= 1'b0;
                m_done  <= 1'b1;
                m_bcd   <= model_bcd(m_cap);
                m_blank <= model_blank(m_cap);
                m_ovf   <= (m_cap > 32'd99999999);
            end else begin
                m_done <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_busy",  64'(busy),     64'(m_busy));
            check("cyc_done",  64'(done),     64'(m_done));
            check("cyc_bcd",   64'(bcd),      64'(m_bcd));
            check("cyc_blank", 64'(blank),    64'(m_blank));
            check("cyc_ovf",   64'(overflow), 64'(m_ovf));
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at a negedge: start is sampled on the next posedge.
    task automatic start_conv(input logic [WIDTH-1:0] v);
        bin   = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the negedge where done is seen; cyc counts cycles from E0.
    task automatic wait_done(input bit noise, output int cyc);
        cyc = 0;
        while (!done && cyc < 100) begin
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                bin   = $urandom;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (!done) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic directed(input string name, input logic [31:0] v,
                            input logic [31:0] e_bcd, input logic [7:0] e_blank,
                            input logic e_ovf);
        int cyc;
        start_conv(v);
        wait_done(1'b0, cyc);
        check({name, "_latency"}, 64'(cyc), 64'(LAT));
        check({name, "_bcd"},     64'(bcd), 64'(e_bcd));
        check({name, "_blank"},   64'(blank), 64'(e_blank));
        check({name, "_ovf"},     64'(overflow), 64'(e_ovf));
    endtask

    initial begin
        int cyc;
        int dones;
        logic [31:0] v;
        logic [31:0] edge_vals [6];

        edge_vals = '{32'd0, 32'd9, 32'd10, 32'd99999999, 32'd100000000, 32'hFFFF_FFFF};

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_bcd",   64'(bcd),      64'h0);
        check("rst_blank", 64'(blank),    64'hFE);
        check("rst_busy",  64'(busy),     64'h0);
        check("rst_done",  64'(done),     64'h0);
        check("rst_ovf",   64'(overflow), 64'h0);

        directed("d12345678", 32'd12345678,  32'h12345678, 8'h00, 1'b0);
        directed("d99999999", 32'd99999999,  32'h99999999, 8'h00, 1'b0);
        directed("d1e8",      32'd100000000, 32'h99999999, 8'h00, 1'b1);
        directed("d42",       32'd42,        32'h00000042, 8'b1111_1100, 1'b0);
        directed("d0",        32'd0,         32'h00000000, 8'b1111_1110, 1'b0);

        // start while busy is ignored; exactly one done with the first value
        start_conv(32'd12345678);
        dones = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 5) begin
                bin   = 32'd555;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) dones++;
            @(negedge clk);
        end
        start = 1'b0;
        check("ign_done_count", 64'(dones), 64'd1);
        check("ign_bcd", 64'(bcd), 64'h12345678);

        // back-to-back: start issued in the cycle right after done
        start_conv(32'd31);
        wait_done(1'b0, cyc);
        start_conv(32'd2024);
        wait_done(1'b0, cyc);
        check("b2b_latency", 64'(cyc), 64'(LAT));
        check("b2b_bcd", 64'(bcd), 64'h00002024);
        check("b2b_blank", 64'(blank), 64'hF0);

        // reset mid-conversion aborts with no done
        start_conv(32'd12345678);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy",  64'(busy),  64'h0);
        check("midrst_bcd",   64'(bcd),   64'h0);
        check("midrst_blank", 64'(blank), 64'hFE);
        check("midrst_ovf",   64'(overflow), 64'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("midrst_no_done", 64'(dones), 64'd0);
        directed("d7", 32'd7, 32'h00000007, 8'hFE, 1'b0);

        // randomized values, optional start/bin noise while busy
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: v = $urandom;
                1: v = $urandom_range(0, 99999999);
                2: v = $urandom_range(0, 999);
                default: v = edge_vals[$urandom_range(0, 5)];
            endcase
            start_conv(v);
            wait_done(1'($urandom_range(0, 1)), cyc);
            check("rnd_latency", 64'(cyc), 64'(LAT));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
